// File: rtl/yolcu_kuyrugu.sv
// Passenger intake queue: record RAM plus one registered presentation stage.
// Optional dispatched-passenger counter enabled by defining YOLCU_SAYAC_EN.
module yolcu_kuyrugu #(
    parameter int unsigned BIT      = 6,
    parameter int unsigned DERINLIK = 8
) (
    input  logic                          saat,
    input  logic                          reset,
    input  logic                          yaz_gecerli,
    output logic                          yaz_hazir,
    input  logic [BIT-1:0]                g_kimlik_no,
    input  logic                          g_uyruk,
    input  logic [5:0]                    g_agirlik,
    input  logic [8:0]                    g_bakiye,
    input  logic                          al,
    output logic                          cikis_gecerli,
    output logic [BIT-1:0]                kimlik_no,
    output logic                          uyruk,
    output logic [5:0]                    agirlik,
    output logic [8:0]                    bakiye,
    output logic [$clog2(DERINLIK):0]     sayi,
    output logic                          tasma,
    output logic [7:0]                    gonderilen
);

    localparam int unsigned AW = $clog2(DERINLIK);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = BIT + 16;
    localparam logic [CW-1:0] Kapasite = CW'(DERINLIK);

    typedef enum logic {StBos, StDolu} durum_t;

    durum_t          durum_q, durum_d;
    logic [RW-1:0]   mem [DERINLIK];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   sayi_q, ram_sayi;
    logic [RW-1:0]   kayit_q;
    logic            tasma_q;
    logic            yaz, al_kabul, ram_dolu, yukle;

    assign yaz_hazir = sayi_q < Kapasite;
    assign yaz       = yaz_gecerli && yaz_hazir;
    assign al_kabul  = al && cikis_gecerli;
    // RAM occupancy excludes the record sitting in the output register.
    assign ram_sayi  = sayi_q - CW'(cikis_gecerli);
    assign ram_dolu  = ram_sayi != '0;
    assign yukle     = (!cikis_gecerli || al_kabul) && ram_dolu;

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            durum_q <= StBos;
        end else begin
            durum_q <= durum_d;
        end
    end

    always_comb begin
        durum_d = durum_q;
        unique case (durum_q)
            StBos:  if (ram_dolu) durum_d = StDolu;
            StDolu: if (al_kabul && !ram_dolu) durum_d = StBos;
            default: durum_d = StBos;
        endcase
    end

    always_comb begin
        cikis_gecerli = (durum_q == StDolu);
    end

    always_ff @(posedge saat) begin
        if (yaz) begin
            mem[wr_ptr_q] <= {g_kimlik_no, g_uyruk, g_agirlik, g_bakiye};
        end
    end

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sayi_q   <= '0;
            kayit_q  <= '0;
            tasma_q  <= 1'b0;
        end else begin
            if (yaz) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (yukle) begin
                kayit_q  <= mem[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end else if (al_kabul) begin
                // Clearing on the final pop keeps the record outputs zero while empty.
                kayit_q <= '0;
            end
            unique case ({yaz, al_kabul})
                2'b10:   sayi_q <= sayi_q + 1'b1;
                2'b01:   sayi_q <= sayi_q - 1'b1;
                default: sayi_q <= sayi_q;
            endcase
            if (yaz_gecerli && !yaz_hazir) begin
                tasma_q <= 1'b1;
            end
        end
    end

    assign kimlik_no = kayit_q[RW-1 -: BIT];
    assign uyruk     = kayit_q[15];
    assign agirlik   = kayit_q[14:9];
    assign bakiye    = kayit_q[8:0];
    assign sayi      = sayi_q;
    assign tasma     = tasma_q;

`ifdef YOLCU_SAYAC_EN
    logic [7:0] gonderilen_q;

    always_ff @(posedge saat or negedge reset) begin
        if (!reset) begin
            gonderilen_q <= 8'd0;
        end else if (al_kabul && gonderilen_q != 8'hFF) begin
            gonderilen_q <= gonderilen_q + 8'd1;
        end
    end

    assign gonderilen = gonderilen_q;
`else
    assign gonderilen = 8'd0;
`endif

endmodule
